card_dealer: RTL and testbench

Consumer of the RNG: turns a one-cycle deal request into a unique playing card from a 52-card deck. It requests random values over a req/valid handshake and rejects out-of-range or already-dealt values. After a bounded number of retries it falls back to a linear scan. It sits between the RNG and the blackjack game FSM.

---
 rtl/card_dealer.sv | 203 ++++++++++++++++++++
 tb/tb_card_dealer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card deck using an external RNG over a req/valid
// handshake, falling back to a linear scan after MAX_RETRIES rejected draws.
module card_dealer #(
   parameter int unsigned MAX_RETRIES = 16
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       deal_req,
   input  logic       shuffle,
   output logic       rnd_req,
   input  logic       rnd_valid,
   input  logic [5:0] rnd_data,
   output logic       card_valid,
   output logic [5:0] card_id,
   output logic [3:0] card_rank,
   output logic [3:0] card_value,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       busy,
   output logic       deal_err
);

   localparam int unsigned NCARDS = 52;
   localparam int unsigned IDW    = 6;
   localparam int unsigned RW     = 6;
   localparam int unsigned VW     = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_CHECK,
      S_SCAN,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [NCARDS-1:0] mask_q, mask_d;
   logic [IDW-1:0]    left_q, left_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic [IDW-1:0]    data_q, data_d;
   logic [IDW-1:0]    idx_q, idx_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [VW-1:0]     rank_q, rank_d;
   logic [VW-1:0]     value_q, value_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              empty_q, empty_d;
   logic              req_q, req_d;
   logic              busy_q, busy_d;

   logic [63:0]       ext_mask;
   logic              draw_taken;
   logic              scan_taken;
   logic [RW-1:0]     retry_inc;
   logic [IDW-1:0]    data_mod;
   logic [IDW-1:0]    idx_next;
   logic [IDW-1:0]    sel;
   logic [IDW-1:0]    rank_idx;
   logic [VW-1:0]     rank_sel;
   logic [VW-1:0]     value_sel;
   logic              take;

   // Values 52..63 index the padding ones, so out-of-range draws look already dealt
   always_comb begin
      ext_mask   = {12'hFFF, mask_q};
      draw_taken = ext_mask[data_q];
      scan_taken = ext_mask[idx_q];
      retry_inc  = retry_q + RW'(1);
      data_mod   = (data_q >= IDW'(NCARDS)) ? data_q - IDW'(NCARDS) : data_q;
      idx_next   = (idx_q == IDW'(NCARDS - 1)) ? '0 : idx_q + IDW'(1);
      sel        = (state_q == S_SCAN) ? idx_q : data_q;
   end

   // Rank and blackjack value of the selected card without a divider
   always_comb begin
      if (sel >= IDW'(39))      rank_idx = sel - IDW'(39);
      else if (sel >= IDW'(26)) rank_idx = sel - IDW'(26);
      else if (sel >= IDW'(13)) rank_idx = sel - IDW'(13);
      else                      rank_idx = sel;
      rank_sel = VW'(rank_idx) + VW'(1);
      if (rank_sel == VW'(1))       value_sel = VW'(11);
      else if (rank_sel >= VW'(10)) value_sel = VW'(10);
      else                          value_sel = rank_sel;
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      left_d  = left_q;
      retry_d = retry_q;
      data_d  = data_q;
      idx_d   = idx_q;
      id_d    = id_q;
      rank_d  = rank_q;
      value_d = value_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      take    = 1'b0;

      if (shuffle) begin
         state_d = S_IDLE;
         mask_d  = '0;
         left_d  = IDW'(NCARDS);
      end else begin
         case (state_q)
            S_IDLE: begin
               if (deal_req) begin
                  if (left_q != '0) begin
                     state_d = S_REQ;
                     retry_d = '0;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (req_q && rnd_valid) begin
                  data_d  = rnd_data;
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               if (!draw_taken) begin
                  take = 1'b1;
               end else begin
                  retry_d = retry_inc;
                  if (retry_inc == RW'(MAX_RETRIES)) begin
                     state_d = S_SCAN;
                     idx_d   = data_mod;
                  end else begin
                     state_d = S_REQ;
                  end
               end
            end
            S_SCAN: begin
               if (!scan_taken) take = 1'b1;
               else             idx_d = idx_next;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase

         if (take) begin
            state_d = S_DONE;
            mask_d  = mask_q | (NCARDS'(1) << sel);
            left_d  = left_q - IDW'(1);
            id_d    = sel;
            rank_d  = rank_sel;
            value_d = value_sel;
            valid_d = 1'b1;
         end
      end

      empty_d = (left_d == '0);
      req_d   = (state_q == S_REQ) && (state_d == S_REQ);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         left_q  <= IDW'(NCARDS);
         retry_q <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         id_q    <= '0;
         rank_q  <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         empty_q <= 1'b0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         left_q  <= left_d;
         retry_q <= retry_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         id_q    <= id_d;
         rank_q  <= rank_d;
         value_q <= value_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         empty_q <= empty_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
      end
   end

   assign rnd_req    = req_q;
   assign card_valid = valid_q;
   assign card_id    = id_q;
   assign card_rank  = rank_q;
   assign card_value = value_q;
   assign cards_left = left_q;
   assign deck_empty = empty_q;
   assign busy       = busy_q;
   assign deal_err   = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed vector table, corner sequences and
// randomized RNG answers checked against a deck model.
module tb_card_dealer;

   localparam int MAXR = 4;

   logic       clk;
   logic       resetn;
   logic       deal_req;
   logic       shuffle;
   logic       rnd_req;
   logic       rnd_valid;
   logic [5:0] rnd_data;
   logic       card_valid;
   logic [5:0] card_id;
   logic [3:0] card_rank;
   logic [3:0] card_value;
   logic [5:0] cards_left;
   logic       deck_empty;
   logic       busy;
   logic       deal_err;

   card_dealer #(.MAX_RETRIES(MAXR)) dut (
      .CLOCK_50  (clk),
      .resetn    (resetn),
      .deal_req  (deal_req),
      .shuffle   (shuffle),
      .rnd_req   (rnd_req),
      .rnd_valid (rnd_valid),
      .rnd_data  (rnd_data),
      .card_valid(card_valid),
      .card_id   (card_id),
      .card_rank (card_rank),
      .card_value(card_value),
      .cards_left(cards_left),
      .deck_empty(deck_empty),
      .busy      (busy),
      .deal_err  (deal_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int ans[4];
      int nans;
      int exp_id;
      int exp_rank;
      int exp_value;
      int exp_left;
      int exp_hs;
   } vec_t;

   vec_t      tbl[5];
   int        tests;
   int        fails;
   bit [51:0] m;
   int        left;
   int        ans_q[$];
   int        used[$];
   bit        rnd_dly;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input int a0, input int a1, input int a2,
                          input int a3, input int n, input int id, input int rk,
                          input int vl, input int lf, input int hs);
      tbl[i].ans[0] = a0; tbl[i].ans[1] = a1; tbl[i].ans[2] = a2; tbl[i].ans[3] = a3;
      tbl[i].nans = n; tbl[i].exp_id = id; tbl[i].exp_rank = rk;
      tbl[i].exp_value = vl; tbl[i].exp_left = lf; tbl[i].exp_hs = hs;
   endtask

   function automatic int exp_rank(input int id);
      return id % 13 + 1;
   endfunction

   function automatic int exp_value(input int id);
      int r;
      r = id % 13 + 1;
      if (r == 1) return 11;
      if (r > 10) return 10;
      return r;
   endfunction

   // Which card the deck rules yield for a sequence of RNG answers
   function automatic int predict(input int ans[$], output int consumed);
      int r;
      int s;
      r = 0;
      consumed = 0;
      foreach (ans[i]) begin
         consumed = i + 1;
         if (ans[i] < 52 && !m[ans[i]]) return ans[i];
         r++;
         if (r == MAXR) begin
            s = ans[i] % 52;
            for (int j = 0; j < 52; j++)
               if (!m[(s + j) % 52]) return (s + j) % 52;
            return -1;
         end
      end
      return -1;
   endfunction

   // Starts at a negedge; returns at the negedge where card_valid is seen
   task automatic do_deal(input bit from_q, output int id, output int hs,
                          output int lat, output bit ok);
      int wait_cnt;
      int a;
      used.delete();
      hs = 0; ok = 0; id = -1; lat = -1;
      wait_cnt = rnd_dly ? int'($urandom_range(0, 2)) : 0;
      deal_req = 1'b1;
      @(negedge clk);
      deal_req = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         if (card_valid) begin
            ok = 1; id = int'(card_id); lat = k;
         end else begin
            if (rnd_valid) rnd_valid = 1'b0;
            else if (rnd_req) begin
               if (wait_cnt > 0) wait_cnt--;
               else begin
                  if (from_q && ans_q.size() > 0) a = ans_q.pop_front();
                  else a = int'($urandom_range(0, 63));
                  rnd_data  = 6'(a);
                  rnd_valid = 1'b1;
                  used.push_back(a);
                  hs++;
                  wait_cnt = rnd_dly ? int'($urandom_range(0, 2)) : 0;
               end
            end
            @(negedge clk);
         end
      end
      rnd_valid = 1'b0;
   endtask

   task automatic check_card(input int id, input int e_id, input int e_left,
                             input int hs, input int e_hs);
      chk("card_id", id, e_id);
      chk("card_rank", int'(card_rank), exp_rank(e_id));
      chk("card_value", int'(card_value), exp_value(e_id));
      chk("cards_left", int'(cards_left), e_left);
      chk("deck_empty", int'(deck_empty), int'(e_left == 0));
      chk("handshakes", hs, e_hs);
      chk("busy_in_done", int'(busy), 1);
      @(negedge clk);
      chk("busy_after", int'(busy), 0);
      chk("valid_pulse", int'(card_valid), 0);
   endtask

   task automatic do_shuffle();
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      m = '0;
      left = 52;
   endtask

   task automatic random_deals(input int n);
      int id, hs, lat, cons, pred;
      bit ok;
      for (int i = 0; i < n; i++) begin
         do_deal(1'b0, id, hs, lat, ok);
         chk("deal_done", int'(ok), 1);
         if (!ok) return;
         pred = predict(used, cons);
         chk("unique", int'(m[id]), 0);
         left--;
         check_card(id, pred, left, hs, cons);
         if (pred >= 0) m[pred] = 1'b1;
      end
   endtask

   initial begin
      int id, hs, lat, cnt, last_id;
      bit ok;
      tests = 0; fails = 0; m = '0; left = 52; rnd_dly = 0;
      resetn = 1'b0; deal_req = 1'b0; shuffle = 1'b0;
      rnd_valid = 1'b0; rnd_data = '0;

      set_vec(0,  5,  0, 0, 0, 1,  5,  6,  6, 51, 1);
      set_vec(1,  5, 17, 0, 0, 2, 17,  5,  5, 50, 2);
      set_vec(2, 60,  0, 0, 0, 2,  0,  1, 11, 49, 2);
      set_vec(3, 12,  0, 0, 0, 1, 12, 13, 10, 48, 1);
      set_vec(4,  5,  5, 5, 5, 4,  6,  7,  7, 47, 4);

      repeat (3) @(negedge clk);
      chk("rst_rnd_req", int'(rnd_req), 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_card_valid", int'(card_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_deal_err", int'(deal_err), 0);
      chk("rst_deck_empty", int'(deck_empty), 0);
      chk("rst_card_id", int'(card_id), 0);
      chk("rst_card_rank", int'(card_rank), 0);
      chk("rst_card_value", int'(card_value), 0);
      chk("rst_cards_left", int'(cards_left), 52);

      // Directed table: basic, duplicate, out-of-range/ace, king, scan fallback
      for (int i = 0; i < 5; i++) begin
         ans_q.delete();
         for (int j = 0; j < tbl[i].nans; j++) ans_q.push_back(tbl[i].ans[j]);
         do_deal(1'b1, id, hs, lat, ok);
         chk("vec_done", int'(ok), 1);
         if (i == 0) chk("min_latency", lat, 3);
         chk("vec_rank", int'(card_rank), tbl[i].exp_rank);
         chk("vec_value", int'(card_value), tbl[i].exp_value);
         check_card(id, tbl[i].exp_id, tbl[i].exp_left, hs, tbl[i].exp_hs);
         m[tbl[i].exp_id] = 1'b1;
         left--;
      end

      // Abort in REQ, then a late rnd_valid
      do_shuffle();
      deal_req = 1'b1;
      @(negedge clk);
      deal_req = 1'b0;
      cnt = 0;
      while (!rnd_req && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      chk("abort_req_seen", int'(rnd_req), 1);
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      chk("abort_rnd_req", int'(rnd_req), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(card_valid), 0);
      rnd_data = 6'd9;
      rnd_valid = 1'b1;
      @(negedge clk);
      rnd_valid = 1'b0;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         cnt += int'(card_valid) + int'(busy) + int'(rnd_req);
         @(negedge clk);
      end
      chk("late_valid_activity", cnt, 0);
      chk("late_cards_left", int'(cards_left), 52);
      ans_q.delete();
      ans_q.push_back(9);
      do_deal(1'b1, id, hs, lat, ok);
      chk("mask_unchanged_done", int'(ok), 1);
      left--;
      check_card(id, 9, left, hs, 1);

      // shuffle and deal_req in the same cycle
      deal_req = 1'b1;
      shuffle = 1'b1;
      @(negedge clk);
      deal_req = 1'b0;
      shuffle = 1'b0;
      m = '0; left = 52;
      chk("shuf_deal_busy", int'(busy), 0);
      @(negedge clk);
      chk("shuf_deal_req", int'(rnd_req), 0);
      chk("shuf_deal_left", int'(cards_left), 52);

      // Exhaust the deck with random answers and delays
      rnd_dly = 1;
      random_deals(52);
      chk("exhaust_left", int'(cards_left), 0);
      chk("exhaust_empty", int'(deck_empty), 1);
      last_id = int'(card_id);
      deal_req = 1'b1;
      @(negedge clk);
      deal_req = 1'b0;
      chk("deal_err_pulse", int'(deal_err), 1);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         cnt += int'(rnd_req) + int'(busy) + int'(deal_err);
      end
      chk("empty_no_activity", cnt, 0);
      do_shuffle();
      chk("reshuffle_left", int'(cards_left), 52);
      chk("reshuffle_empty", int'(deck_empty), 0);
      chk("card_held", int'(card_id), last_id);

      rnd_dly = 0;
      random_deals(20);
      rnd_dly = 1;
      random_deals(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
